// File: rtl/rv32i_decode_stage.sv
// rv32i_decode_stage: registered RV32I decode stage with a two-entry skid buffer.
// Decodes in_instr combinationally and captures the control bundle on accept.
// The head entry drives all out_* ports directly, so every output is a flop.
//
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   flush                    drop all buffered entries on the next edge
//   in_valid/in_ready        upstream handshake; in_instr, in_pc payload
//   out_valid/out_ready      downstream handshake
//   out_alu_op, out_op_func  ALU control
//   out_imm                  sign-extended immediate (0 for R-type)
//   out_rs1/rs2/rd           register indices
//   out_src1_pc/src2_imm     operand selects
//   out_reg_we, out_mem_rd, out_mem_wr, out_branch, out_jump   enables
//   out_pc, out_illegal      PC of the presented entry, illegal flag
//
// Build option: define DECODE_ILLEGAL_CHK_EN to enable the illegal-instruction
// check; otherwise out_illegal is 0 and unknown opcodes decode as NOP.
module rv32i_decode_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  out_alu_op,
    output logic [4:0]  out_op_func,
    output logic [31:0] out_imm,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic [4:0]  out_rd,
    output logic        out_src1_pc,
    output logic        out_src2_imm,
    output logic        out_reg_we,
    output logic        out_mem_rd,
    output logic        out_mem_wr,
    output logic        out_branch,
    output logic        out_jump,
    output logic [31:0] out_pc,
    output logic        out_illegal
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned REGW = 5;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef struct packed {
        logic [1:0]      alu_op;
        logic [4:0]      op_func;
        logic [XLEN-1:0] imm;
        logic [REGW-1:0] rs1;
        logic [REGW-1:0] rs2;
        logic [REGW-1:0] rd;
        logic            src1_pc;
        logic            src2_imm;
        logic            reg_we;
        logic            mem_rd;
        logic            mem_wr;
        logic            branch;
        logic            jump;
        logic            illegal;
        logic [XLEN-1:0] pc;
    } dec_t;

    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;

    state_t          state;
    dec_t            head;
    dec_t            tail;
    dec_t            dec_c;
    logic            known_c;
    logic [XLEN-1:0] imm_i_c, imm_s_c, imm_b_c, imm_u_c, imm_j_c;
    logic            accept_c;
    logic            consume_c;

    // Immediate formats, all sign-extended from instr[31]
    always_comb begin
        imm_i_c = {{20{in_instr[31]}}, in_instr[31:20]};
        imm_s_c = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        imm_b_c = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
        imm_u_c = {in_instr[31:12], 12'b0};
        imm_j_c = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
    end

    // Opcode decode into the control bundle
    always_comb begin
        dec_c         = '0;
        known_c       = 1'b1;
        dec_c.op_func = {in_instr[5], in_instr[30], in_instr[14:12]};
        dec_c.rs1     = in_instr[19:15];
        dec_c.rd      = in_instr[11:7];
        dec_c.pc      = in_pc;
        case (in_instr[6:0])
            OPC_OP: begin
                dec_c.rs2    = in_instr[24:20];
                dec_c.reg_we = 1'b1;
            end
            OPC_OP_IMM: begin
                dec_c.imm      = imm_i_c;
                dec_c.src2_imm = 1'b1;
                dec_c.reg_we   = 1'b1;
            end
            OPC_LOAD: begin
                dec_c.alu_op   = 2'b01;
                dec_c.imm      = imm_i_c;
                dec_c.src2_imm = 1'b1;
                dec_c.mem_rd   = 1'b1;
                dec_c.reg_we   = 1'b1;
            end
            OPC_STORE: begin
                dec_c.alu_op   = 2'b01;
                dec_c.imm      = imm_s_c;
                dec_c.rs2      = in_instr[24:20];
                dec_c.rd       = '0;
                dec_c.src2_imm = 1'b1;
                dec_c.mem_wr   = 1'b1;
            end
            OPC_BRANCH: begin
                dec_c.alu_op = 2'b11;
                dec_c.imm    = imm_b_c;
                dec_c.rs2    = in_instr[24:20];
                dec_c.rd     = '0;
                dec_c.branch = 1'b1;
            end
            OPC_LUI: begin
                dec_c.alu_op   = 2'b01;
                dec_c.imm      = imm_u_c;
                dec_c.rs1      = '0;
                dec_c.src2_imm = 1'b1;
                dec_c.reg_we   = 1'b1;
            end
            OPC_AUIPC: begin
                dec_c.alu_op   = 2'b01;
                dec_c.imm      = imm_u_c;
                dec_c.src1_pc  = 1'b1;
                dec_c.src2_imm = 1'b1;
                dec_c.reg_we   = 1'b1;
            end
            OPC_JAL: begin
                dec_c.alu_op   = 2'b01;
                dec_c.imm      = imm_j_c;
                dec_c.src1_pc  = 1'b1;
                dec_c.src2_imm = 1'b1;
                dec_c.jump     = 1'b1;
                dec_c.reg_we   = 1'b1;
            end
            OPC_JALR: begin
                dec_c.alu_op   = 2'b01;
                dec_c.imm      = imm_i_c;
                dec_c.src2_imm = 1'b1;
                dec_c.jump     = 1'b1;
                dec_c.reg_we   = 1'b1;
            end
            default: known_c = 1'b0;
        endcase
`ifdef DECODE_ILLEGAL_CHK_EN
        dec_c.illegal = !known_c || (in_instr[1:0] != 2'b11);
        // BNE/BLTU/BGEU need compares the ALU does not produce
        if (in_instr[6:0] == OPC_BRANCH &&
            (in_instr[14:12] == 3'b001 || in_instr[14:12] == 3'b110 || in_instr[14:12] == 3'b111))
            dec_c.illegal = 1'b1;
        if (in_instr[6:0] == OPC_OP) begin
            if (in_instr[31:25] != 7'b0000000 && in_instr[31:25] != 7'b0100000)
                dec_c.illegal = 1'b1;
            if (in_instr[31:25] == 7'b0100000 && in_instr[14:12] != 3'b000 && in_instr[14:12] != 3'b101)
                dec_c.illegal = 1'b1;
        end
        if (in_instr[6:0] == OPC_OP_IMM) begin
            if (in_instr[14:12] == 3'b001 && in_instr[31:25] != 7'b0000000)
                dec_c.illegal = 1'b1;
            if (in_instr[14:12] == 3'b101 && in_instr[31:25] != 7'b0000000 && in_instr[31:25] != 7'b0100000)
                dec_c.illegal = 1'b1;
        end
        // An illegal entry must not cause any architectural side effect
        if (dec_c.illegal) begin
            dec_c.reg_we = 1'b0;
            dec_c.mem_rd = 1'b0;
            dec_c.mem_wr = 1'b0;
            dec_c.branch = 1'b0;
            dec_c.jump   = 1'b0;
        end
`else
        dec_c.illegal = 1'b0;
`endif
    end

    assign accept_c  = in_valid && in_ready;
    assign consume_c = out_valid && out_ready;

    // Skid-buffer FSM: head feeds the outputs, tail holds the second entry
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            head      <= '0;
            tail      <= '0;
        end else if (flush) begin
            state     <= ST_EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept_c) begin
                        head      <= dec_c;
                        state     <= ST_ONE;
                        out_valid <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept_c && !consume_c) begin
                        tail     <= dec_c;
                        state    <= ST_TWO;
                        in_ready <= 1'b0;
                    end else if (!accept_c && consume_c) begin
                        state     <= ST_EMPTY;
                        out_valid <= 1'b0;
                    end else if (accept_c && consume_c) begin
                        head <= dec_c;
                    end
                end
                ST_TWO: begin
                    if (consume_c) begin
                        head     <= tail;
                        state    <= ST_ONE;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_alu_op   = head.alu_op;
    assign out_op_func  = head.op_func;
    assign out_imm      = head.imm;
    assign out_rs1      = head.rs1;
    assign out_rs2      = head.rs2;
    assign out_rd       = head.rd;
    assign out_src1_pc  = head.src1_pc;
    assign out_src2_imm = head.src2_imm;
    assign out_reg_we   = head.reg_we;
    assign out_mem_rd   = head.mem_rd;
    assign out_mem_wr   = head.mem_wr;
    assign out_branch   = head.branch;
    assign out_jump     = head.jump;
    assign out_pc       = head.pc;
    assign out_illegal  = head.illegal;

endmodule

// File: tb/tb_rv32i_decode_stage.sv
// Scoreboard bench for rv32i_decode_stage: a driver issues directed instructions
// and pushes hand-computed bundles; a negedge monitor pops and compares on every
// downstream transfer. Handshake, flush and reset behaviour are checked inline.
module tb_rv32i_decode_stage;

    typedef struct packed {
        logic [1:0]  alu_op;
        logic [4:0]  op_func;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        src1_pc;
        logic        src2_imm;
        logic        reg_we;
        logic        mem_rd;
        logic        mem_wr;
        logic        branch;
        logic        jump;
        logic        illegal;
        logic [31:0] pc;
    } bundle_t;

    localparam int NV = 11;

    logic        clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, in_pc;
    logic [1:0]  out_alu_op;
    logic [4:0]  out_op_func, out_rs1, out_rs2, out_rd;
    logic [31:0] out_imm, out_pc;
    logic        out_src1_pc, out_src2_imm, out_reg_we, out_mem_rd, out_mem_wr;
    logic        out_branch, out_jump, out_illegal;

    bundle_t     act;
    bundle_t     cur_exp;
    bundle_t     sb[$];
    bundle_t     vexp[NV];
    logic [31:0] vins[NV];
    int          n_checks, n_pass;

    rv32i_decode_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_alu_op(out_alu_op), .out_op_func(out_op_func), .out_imm(out_imm),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_src1_pc(out_src1_pc), .out_src2_imm(out_src2_imm),
        .out_reg_we(out_reg_we), .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr),
        .out_branch(out_branch), .out_jump(out_jump),
        .out_pc(out_pc), .out_illegal(out_illegal)
    );

    assign act = {out_alu_op, out_op_func, out_imm, out_rs1, out_rs2, out_rd,
                  out_src1_pc, out_src2_imm, out_reg_we, out_mem_rd, out_mem_wr,
                  out_branch, out_jump, out_illegal, out_pc};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    // flags = {src1_pc, src2_imm, reg_we, mem_rd, mem_wr, branch, jump, illegal}
    function automatic bundle_t mk(input logic [1:0] alu, input logic [4:0] opf,
                                   input logic [31:0] imm, input logic [4:0] rs1,
                                   input logic [4:0] rs2, input logic [4:0] rd,
                                   input logic [7:0] flags);
        bundle_t b;
        b = '0;
        b.alu_op  = alu;
        b.op_func = opf;
        b.imm     = imm;
        b.rs1     = rs1;
        b.rs2     = rs2;
        b.rd      = rd;
        {b.src1_pc, b.src2_imm, b.reg_we, b.mem_rd, b.mem_wr, b.branch, b.jump, b.illegal} = flags;
        return b;
    endfunction

    task automatic chk_b(input string nm, input bundle_t a, input bundle_t e);
        n_checks++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got %h required %h", nm, a, e);
    endtask

    task automatic chk1(input string nm, input logic a, input logic e);
        n_checks++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got %b required %b", nm, a, e);
    endtask

    // Scoreboard monitor: flush/reset discard everything still queued
    always @(negedge clk) begin
        if (!rst_n || flush) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_output: got pc %h required no transfer", out_pc);
                end else begin
                    chk_b("xfer", act, sb.pop_front());
                end
            end
            if (in_valid && in_ready) sb.push_back(cur_exp);
        end
    end

    // Present one instruction and hold it until accepted
    task automatic send(input int idx, input logic [31:0] pc);
        bundle_t e;
        int      t;
        e        = vexp[idx];
        e.pc     = pc;
        cur_exp  = e;
        in_instr = vins[idx];
        in_pc    = pc;
        in_valid = 1'b1;
        t = 0;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                break;
            end
            t++;
            if (t > 50) begin
                n_checks++;
                $display("FAIL accept_timeout: got in_ready 0 required 1 within 50 cycles");
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int t;
        t = 0;
        while (sb.size() != 0 && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        n_checks++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL %s_drain: got %0d pending required 0", nm, sb.size());
        chk1({nm, "_idle"}, out_valid, 1'b0);
    endtask

    function automatic bundle_t with_pc(input int idx, input logic [31:0] pc);
        bundle_t b;
        b    = vexp[idx];
        b.pc = pc;
        return b;
    endfunction

    initial begin
        n_checks = 0;
        n_pass   = 0;
        // op_func takes instr[30] as-is, so addi -5 (imm sign bit set) gives 01000
        vins[0] = 32'hFFB10093; vexp[0] = mk(2'b00, 5'b01000, 32'hFFFFFFFB, 5'd2, 5'd0, 5'd1, 8'b01100000);
        vins[1] = 32'h402081B3; vexp[1] = mk(2'b00, 5'b11000, 32'h0,        5'd1, 5'd2, 5'd3, 8'b00100000);
        vins[2] = 32'h00208463; vexp[2] = mk(2'b11, 5'b10000, 32'h8,        5'd1, 5'd2, 5'd0, 8'b00000100);
        vins[3] = 32'h00C32283; vexp[3] = mk(2'b01, 5'b00010, 32'hC,        5'd6, 5'd0, 5'd5, 8'b01110000);
        vins[4] = 32'hFE742E23; vexp[4] = mk(2'b01, 5'b11010, 32'hFFFFFFFC, 5'd8, 5'd7, 5'd0, 8'b01001000);
        vins[5] = 32'hFF9FF0EF; vexp[5] = mk(2'b01, 5'b11111, 32'hFFFFFFF8, 5'd31, 5'd0, 5'd1, 8'b11100010);
        vins[6] = 32'h00008067; vexp[6] = mk(2'b01, 5'b10000, 32'h0,        5'd1, 5'd0, 5'd0, 8'b01100010);
        vins[7] = 32'h12345537; vexp[7] = mk(2'b01, 5'b10101, 32'h12345000, 5'd0, 5'd0, 5'd10, 8'b01100000);
        vins[8] = 32'h00001097; vexp[8] = mk(2'b01, 5'b00001, 32'h1000,     5'd0, 5'd0, 5'd1, 8'b11100000);
        vins[9] = 32'h00000000;
        vins[10] = 32'h00209463;
`ifdef DECODE_ILLEGAL_CHK_EN
        vexp[9]  = mk(2'b00, 5'b00000, 32'h0, 5'd0, 5'd0, 5'd0, 8'b00000001);
        vexp[10] = mk(2'b11, 5'b10001, 32'h8, 5'd1, 5'd2, 5'd0, 8'b00000001);
`else
        vexp[9]  = mk(2'b00, 5'b00000, 32'h0, 5'd0, 5'd0, 5'd0, 8'b00000000);
        vexp[10] = mk(2'b11, 5'b10001, 32'h8, 5'd1, 5'd2, 5'd0, 8'b00000100);
`endif

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0; cur_exp = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_b("reset_outputs", act, '0);
        chk1("reset_out_valid", out_valid, 1'b0);
        chk1("reset_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Streaming at full rate
        out_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            send(i, 32'h1000 + 32'(4 * i));
            if (i == 0) begin
                chk1("latency_valid", out_valid, 1'b1);
                chk_b("latency_bundle", act, with_pc(0, 32'h1000));
            end
        end
        drain("stream");

        // Backpressure: fill both entries, then release
        out_ready = 1'b0;
        send(0, 32'h2000);
        chk1("one_in_ready", in_ready, 1'b1);
        send(1, 32'h2004);
        chk1("two_in_ready", in_ready, 1'b0);
        chk1("two_out_valid", out_valid, 1'b1);
        in_instr = vins[2]; in_pc = 32'h2008; cur_exp = with_pc(2, 32'h2008); in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk1("stall_in_ready", in_ready, 1'b0);
            chk_b("stall_hold", act, with_pc(0, 32'h2000));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(2, 32'h2008);
        drain("bp");

        // Flush from TWO with a competing input
        out_ready = 1'b0;
        send(3, 32'h3000);
        send(4, 32'h3004);
        in_instr = vins[5]; in_pc = 32'h3008; cur_exp = with_pc(5, 32'h3008);
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk1("flush_out_valid", out_valid, 1'b0);
        chk1("flush_in_ready", in_ready, 1'b1);
        chk_b("flush_hold", act, with_pc(3, 32'h3000));
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk1("flush_no_capture", out_valid, 1'b0);

        // Reset mid-stream from TWO
        out_ready = 1'b0;
        send(6, 32'h4000);
        send(7, 32'h4004);
        in_instr = vins[8]; in_pc = 32'h4008; in_valid = 1'b1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; in_valid = 1'b0;
        chk_b("midreset_outputs", act, '0);
        chk1("midreset_out_valid", out_valid, 1'b0);
        chk1("midreset_in_ready", in_ready, 1'b1);

        // Decode still correct after reset
        out_ready = 1'b1;
        for (int i = 7; i < NV; i++) send(i, 32'h5000 + 32'(4 * i));
        drain("post");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
